fifo_level: RTL and testbench

//  Synchronous single-clock FIFO; parametrised successor to the basic FIFO.

---
 rtl/fifo_level.sv | 160 ++++++++++++++++
 tb/tb_fifo_level.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_level.sv
// Single-clock FIFO with occupancy count, almost flags, flush and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module fifo_level #(
  parameter int DATA_WIDTH = 8,
  parameter int ADR_WIDTH  = 8,
  parameter int AF_LEVEL   = (2**ADR_WIDTH) - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  WEN,
  input  logic [DATA_WIDTH-1:0] WDAT,
  input  logic                  REN,
  output logic [DATA_WIDTH-1:0] RDAT,
  output logic                  RDAT_EN,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_EMPTY,
  output logic [ADR_WIDTH:0]    COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  input  logic                  CLR_ERR
);

  localparam int DEPTH = 2**ADR_WIDTH;
  localparam logic [ADR_WIDTH:0] CNT_FULL = (ADR_WIDTH+1)'(DEPTH);
  localparam logic [ADR_WIDTH:0] CNT_AF   = (ADR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADR_WIDTH:0] CNT_AE   = (ADR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADR_WIDTH:0] CNT_ONE  = (ADR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADR_WIDTH-1:0]  wadr_q, wadr_d;
  logic [ADR_WIDTH-1:0]  radr_q, radr_d;
  logic [ADR_WIDTH:0]    count_q, count_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                  rdat_en_q, rdat_en_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic                  empty_q, empty_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic wr_ok;
  logic rd_ok;
  logic ovf_evt;
  logic unf_evt;
  logic mem_rd;

  always_comb begin
    wr_ok   = WEN & ~full_q & ~FLUSH;
    rd_ok   = REN & ~empty_q & ~FLUSH;
    ovf_evt = WEN & full_q & ~FLUSH;
    unf_evt = REN & empty_q & ~FLUSH;
  end

`ifdef FIFO_FWFT_EN
  // Words still in the array; the head may already sit in the output reg.
  logic [ADR_WIDTH:0] mem_cnt;

  always_comb begin
    mem_cnt = count_q - {{ADR_WIDTH{1'b0}}, rdat_en_q};
    mem_rd  = (mem_cnt != '0) & (~rdat_en_q | rd_ok) & ~FLUSH;
  end
`else
  always_comb begin
    mem_rd = rd_ok;
  end
`endif

  always_comb begin
    wadr_d = wadr_q + ADR_WIDTH'(wr_ok);
    radr_d = radr_q + ADR_WIDTH'(mem_rd);

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    rdat_d = rdat_q;
    if (mem_rd) begin
      rdat_d = mem[radr_q];
    end

`ifdef FIFO_FWFT_EN
    rdat_en_d = mem_rd | (rdat_en_q & ~rd_ok);
`else
    rdat_en_d = rd_ok;
`endif

    if (FLUSH) begin
      wadr_d    = '0;
      radr_d    = '0;
      count_d   = '0;
      rdat_en_d = 1'b0;
    end

    full_d   = (count_d == CNT_FULL);
    afull_d  = (count_d >= CNT_AF);
    aempty_d = (count_d <= CNT_AE);
`ifdef FIFO_FWFT_EN
    empty_d  = ~rdat_en_d;
`else
    empty_d  = (count_d == '0);
`endif

    // A fresh error event wins over a same-cycle clear.
    ovf_d = (ovf_q & ~CLR_ERR) | ovf_evt;
    unf_d = (unf_q & ~CLR_ERR) | unf_evt;
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wadr_q] <= WDAT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wadr_q    <= '0;
      radr_q    <= '0;
      count_q   <= '0;
      rdat_q    <= '0;
      rdat_en_q <= 1'b0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      empty_q   <= 1'b1;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wadr_q    <= wadr_d;
      radr_q    <= radr_d;
      count_q   <= count_d;
      rdat_q    <= rdat_d;
      rdat_en_q <= rdat_en_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      empty_q   <= empty_d;
      aempty_q  <= aempty_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign RDAT         = rdat_q;
  assign RDAT_EN      = rdat_en_q;
  assign FULL         = full_q;
  assign ALMOST_FULL  = afull_q;
  assign EMPTY        = empty_q;
  assign ALMOST_EMPTY = aempty_q;
  assign COUNT        = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_fifo_level.sv
// Directed bench for fifo_level: queue-based reference model plus literal checks.
// Default build checks standard mode; FIFO_FWFT_EN selects the fall-through sequence.
module tb_fifo_level;
  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] wdat = '0;

  logic [7:0] rdat;
  logic       rdat_en, full, afull, empty, aempty, ovf, unf;
  logic [8:0] count;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [7:0] q[$];
  logic [7:0] m_rdat = '0;
  bit         m_rdat_en = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;

  always #5 clk = ~clk;

  fifo_level dut (
    .CLK(clk), .RESET(rst), .FLUSH(flush),
    .WEN(wen), .WDAT(wdat), .REN(ren),
    .RDAT(rdat), .RDAT_EN(rdat_en),
    .FULL(full), .ALMOST_FULL(afull),
    .EMPTY(empty), .ALMOST_EMPTY(aempty),
    .COUNT(count), .OVERFLOW(ovf), .UNDERFLOW(unf),
    .CLR_ERR(clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a plain queue, updated once per clock edge.
  task automatic model_edge();
    bit f, e;
    if (rst) begin
      q.delete();
      m_rdat = '0;
      m_rdat_en = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (flush) begin
      q.delete();
      m_rdat_en = 1'b0;
      if (clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
    end else begin
      f = (q.size() == DEPTH);
      e = (q.size() == 0);
      m_rdat_en = ren && !e;
      if (ren && !e) m_rdat = q.pop_front();
      if (wen && !f) q.push_back(wdat);
      m_ovf = (m_ovf && !clr) || (wen && f);
      m_unf = (m_unf && !clr) || (ren && e);
    end
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit r,
                      input bit fl = 1'b0, input bit c = 1'b0, input bit rs = 1'b0);
    @(negedge clk);
    wen = w; wdat = d; ren = r; flush = fl; clr = c; rst = rs;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("almost_full", 32'(afull), 32'(q.size() >= DEPTH - 4));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("almost_empty", 32'(aempty), 32'(q.size() <= 4));
      chk("overflow", 32'(ovf), 32'(m_ovf));
      chk("underflow", 32'(unf), 32'(m_unf));
      chk("rdat_en", 32'(rdat_en), 32'(m_rdat_en));
      chk("rdat", 32'(rdat), 32'(m_rdat));
    end
  end

  initial begin
    logic [7:0] t1 [3];
    t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h33;

    step(0, 8'h00, 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0, 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_almost_empty", 32'(aempty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_rdat_en", 32'(rdat_en), 0);

`ifdef FIFO_FWFT_EN
    step(1, 8'hA5, 0);
    chk("fwft_count1", 32'(count), 1);
    chk("fwft_not_yet", 32'(rdat_en), 0);
    step(0, 8'h00, 0);
    chk("fwft_rdat_en", 32'(rdat_en), 1);
    chk("fwft_rdat", 32'(rdat), 32'h a5);
    chk("fwft_empty0", 32'(empty), 0);
    step(0, 8'h00, 1);
    chk("fwft_empty1", 32'(empty), 1);
    chk("fwft_count0", 32'(count), 0);
    step(1, 8'h01, 0);
    step(1, 8'h02, 0);
    step(1, 8'h03, 0);
    chk("fwft_head1", 32'(rdat), 1);
    step(0, 8'h00, 1);
    chk("fwft_head2", 32'(rdat), 2);
    step(0, 8'h00, 1);
    chk("fwft_head3", 32'(rdat), 3);
    chk("fwft_valid3", 32'(rdat_en), 1);
    step(0, 8'h00, 1);
    chk("fwft_drained", 32'(empty), 1);
    chk("fwft_drained_cnt", 32'(count), 0);
`else
    chk_en = 1'b1;

    for (int i = 0; i < 3; i++) step(1, t1[i], 0);
    chk("t1_count", 32'(count), 3);
    chk("t1_empty", 32'(empty), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 1);
      chk("t1_rdat", 32'(rdat), 32'(t1[i]));
      chk("t1_rdat_en", 32'(rdat_en), 1);
    end
    step(0, 8'h00, 0);
    chk("t1_pulse_end", 32'(rdat_en), 0);
    chk("t1_empty_end", 32'(empty), 1);
    chk("t1_rdat_hold", 32'(rdat), 32'h33);

    for (int i = 0; i < DEPTH; i++) begin
      step(1, 8'(i), 0);
      if (i == 250) chk("t2_af_251", 32'(afull), 0);
      if (i == 251) chk("t2_af_252", 32'(afull), 1);
      if (i == 254) chk("t2_full_255", 32'(full), 0);
      if (i == 255) chk("t2_full_256", 32'(full), 1);
    end
    step(1, 8'hEE, 0);
    chk("t2_ovf", 32'(ovf), 1);
    chk("t2_count", 32'(count), 256);
    step(0, 8'h00, 0, 0, 1);
    chk("t2_ovf_clr", 32'(ovf), 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 8'h00, 1);
      if (i == 0) chk("t2_first", 32'(rdat), 0);
      if (i == DEPTH - 1) chk("t2_last", 32'(rdat), 32'hff);
    end
    step(0, 8'h00, 0);

    step(0, 8'h00, 1);
    chk("t3_unf", 32'(unf), 1);
    chk("t3_no_rdat_en", 32'(rdat_en), 0);
    step(0, 8'h00, 0, 0, 1);
    chk("t3_unf_clr", 32'(unf), 0);
    step(1, 8'h5A, 1);
    chk("t3_wr_only", 32'(count), 1);
    chk("t3_unf_wr_rd", 32'(unf), 1);
    step(0, 8'h00, 1, 0, 1);
    chk("t3_rd_5a", 32'(rdat), 32'h5a);
    chk("t3_unf_clr2", 32'(unf), 0);
    step(0, 8'h00, 1, 0, 1);
    chk("t3_set_wins", 32'(unf), 1);
    step(0, 8'h00, 0, 0, 1);

    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0);
    for (int i = 0; i < 300; i++) begin
      step(1, 8'(i), 1);
      if (i == 0) chk("t4_first", 32'(rdat), 32'hc0);
    end
    chk("t4_count", 32'(count), 5);
    for (int i = 0; i < 251; i++) step(1, 8'(8'h80 + i), 0);
    chk("t4_full", 32'(full), 1);
    step(1, 8'h77, 1);
    chk("t4_full_rw_cnt", 32'(count), 255);
    chk("t4_full_rw_ovf", 32'(ovf), 1);
    chk("t4_full_rw_rd", 32'(rdat), 32'h27);

    step(0, 8'h00, 0, 1);
    chk("t5_flush_cnt", 32'(count), 0);
    chk("t5_flush_keep", 32'(ovf), 1);
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 8'(8'h40 + i), 0);
    chk("t5_count10", 32'(count), 10);
    step(1, 8'h99, 0, 1);
    chk("t5_fl_cnt", 32'(count), 0);
    chk("t5_fl_empty", 32'(empty), 1);
    chk("t5_fl_ae", 32'(aempty), 1);
    step(0, 8'h00, 1, 1);
    chk("t5_fl_no_unf", 32'(unf), 0);
    step(0, 8'h00, 1);
    for (int i = 0; i < 3; i++) step(1, 8'(8'h60 + i), 0);
    step(1, 8'hAB, 1, 0, 0, 1);
    chk("t5_rst_cnt", 32'(count), 0);
    chk("t5_rst_unf", 32'(unf), 0);
    chk("t5_rst_rdat", 32'(rdat), 0);
    chk("t5_rst_empty", 32'(empty), 1);
    step(0, 8'h00, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
